// File: rtl/branch_pkg.sv
// ============================================================================
// Module : branch_pkg
// Brief  : Opcode / func / rt_field encodings and next-PC select codes shared
//          by the branch resolution unit and its condition evaluator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;

    // REGIMM sub-ops carried in the rt field, instruction bits [20:16]
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // Next-PC mux select codes
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BR     = 2'b01;
    localparam logic [1:0] PC_JMP    = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

endpackage : branch_pkg

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module : branch_cond
// Brief  : Pure-combinational condition evaluator for conditional branches.
//          taken is high only for a conditional branch whose signed
//          comparison holds; every other opcode yields 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
    import branch_pkg::*;
(
    input  logic        [5:0]  op,
    input  logic        [4:0]  rt_field,
    input  logic signed [31:0] rs,
    input  logic signed [31:0] rt,
    output logic               taken
);

    // Evaluate the branch condition selected by op (and rt_field for REGIMM)
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_REGIMM: begin
                case (rt_field)
                    RT_BLTZ, RT_BLTZAL: taken = (rs <  32'sd0);
                    RT_BGEZ, RT_BGEZAL: taken = (rs >= 32'sd0);
                    default:            taken = 1'b0;
                endcase
            end
            OP_BEQ:  taken = (rs == rt);
            OP_BNE:  taken = (rs != rt);
            OP_BLEZ: taken = (rs <= 32'sd0);
            OP_BGTZ: taken = (rs >  32'sd0);
            default: taken = 1'b0;
        endcase
    end

endmodule : branch_cond

`default_nettype wire

// File: rtl/branch.sv
// ============================================================================
// Module : branch
// Brief  : MIPS-style branch/jump resolution. Decodes op/func/rt_field,
//          drives the next-PC select combinationally and as a registered
//          copy. Optional statistics counters are built only when the
//          BRANCH_STATS_EN macro is defined; otherwise they read constant 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [4:0]  rt_field,
    input  logic [5:0]  func,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [1:0]  pc_src,
    output logic [1:0]  pc_src_q,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);

    logic w_taken;

    branch_cond u_cond (
        .op       (op),
        .rt_field (rt_field),
        .rs       (rs),
        .rt       (rt),
        .taken    (w_taken)
    );

    // Next-PC select decode; reset intentionally has no effect here
    always_comb begin
        pc_src = PC_SEQ;
        case (op)
            OP_RTYPE: begin
                if (func == FN_JR || func == FN_JALR) begin
                    pc_src = PC_REG;
                end
            end
            OP_J, OP_JAL: pc_src = PC_JMP;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                if (w_taken) begin
                    pc_src = PC_BR;
                end
            end
            default: pc_src = PC_SEQ;
        endcase
    end

    // Registered copy of the select, one cycle behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_src_q <= PC_SEQ;
        end else begin
            pc_src_q <= pc_src;
        end
    end

`ifdef BRANCH_STATS_EN
    logic        w_is_br;
    logic [31:0] br_count_q,    br_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    // Classify the instruction as a recognised branch/jump, taken or not
    always_comb begin
        w_is_br = 1'b0;
        case (op)
            OP_RTYPE:  w_is_br = (func == FN_JR) || (func == FN_JALR);
            OP_REGIMM: w_is_br = (rt_field == RT_BLTZ)   || (rt_field == RT_BGEZ) ||
                                 (rt_field == RT_BLTZAL) || (rt_field == RT_BGEZAL);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_is_br = 1'b1;
            default:   w_is_br = 1'b0;
        endcase
    end

    // Counter next-state; natural 32-bit wrap from all-ones to zero
    always_comb begin
        br_count_d    = br_count_q    + {31'd0, w_is_br};
        taken_count_d = taken_count_q + {31'd0, (pc_src != PC_SEQ)};
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`else
    assign br_count    = 32'd0;
    assign taken_count = 32'd0;
`endif

endmodule : branch

`default_nettype wire

// File: tb/tb_branch.sv
// ============================================================================
// Module : tb_branch
// Brief  : Self-checking bench for the branch resolution unit: a table of
//          directed decode vectors plus hand-written reset / counter
//          sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [4:0]  rt_field;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  pc_src;
    logic [1:0]  pc_src_q;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    int n_cmp;
    int n_err;

    branch dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .rt_field    (rt_field),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .pc_src      (pc_src),
        .pc_src_q    (pc_src_q),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt_field;
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [1:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [4:0] rf, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] e,
                       input string nm);
        vec_t v;
        v.op = o; v.rt_field = rf; v.func = fn; v.rs = a; v.rt = b; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] o, input logic [4:0] rf, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        op = o; rt_field = rf; func = fn; rs = a; rt = b;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(6'd8, 5'd0, 6'd0, 32'd0, 32'd0);

        // Opcode sweep 0..9 with func=JALR, rt_field=BGEZ, rs=-4, rt=12
        add(6'd0, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b11, "sweep_op0");
        add(6'd1, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b00, "sweep_op1");
        add(6'd2, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b10, "sweep_op2");
        add(6'd3, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b10, "sweep_op3");
        add(6'd4, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b00, "sweep_op4");
        add(6'd5, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b01, "sweep_op5");
        add(6'd6, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b01, "sweep_op6");
        add(6'd7, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b00, "sweep_op7");
        add(6'd8, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b00, "sweep_op8");
        add(6'd9, 5'b00001, 6'b001001, -32'sd4, 32'd12, 2'b00, "sweep_op9");
        // rs = 0 boundaries
        add(6'd1, 5'b00001, 6'd0, 32'd0, 32'd0, 2'b01, "zero_bgez");
        add(6'd1, 5'b00000, 6'd0, 32'd0, 32'd0, 2'b00, "zero_bltz");
        add(6'd6, 5'b00000, 6'd0, 32'd0, 32'd0, 2'b01, "zero_blez");
        add(6'd7, 5'b00000, 6'd0, 32'd0, 32'd0, 2'b00, "zero_bgtz");
        // Most-negative operand
        add(6'd4, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 2'b01, "beq_minneg");
        add(6'd5, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 2'b00, "bne_minneg");
        add(6'd1, 5'b10000, 6'd0, 32'h8000_0000, 32'd0, 2'b01, "bltzal_minneg");
        add(6'd1, 5'b10001, 6'd0, 32'h8000_0000, 32'd0, 2'b00, "bgezal_minneg");
        add(6'd7, 5'd0, 6'd0, 32'h7FFF_FFFF, 32'd0, 2'b01, "bgtz_maxpos");
        add(6'd6, 5'd0, 6'd0, 32'h7FFF_FFFF, 32'd0, 2'b00, "blez_maxpos");
        // Non-branch decodes
        add(6'd0, 5'd0, 6'b100000, 32'd0, 32'd0, 2'b00, "rtype_add");
        add(6'd1, 5'b00010, 6'd0, -32'sd1, 32'd0, 2'b00, "regimm_other");
        add(6'd0, 5'd0, 6'b001000, 32'd1, 32'd2, 2'b11, "jr");
        add(6'd4, 5'd0, 6'd0, 32'd5, 32'd5, 2'b01, "beq_last");

        #1;
        check("reset_pc_src_q", {30'd0, pc_src_q}, 32'd0);
        check("reset_br_count", br_count, 32'd0);
        check("reset_taken_count", taken_count, 32'd0);

        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rt_field, vecs[i].func, vecs[i].rs, vecs[i].rt);
            #1;
            check({vecs[i].name, "_comb"}, {30'd0, pc_src}, {30'd0, vecs[i].exp});
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q"}, {30'd0, pc_src_q}, {30'd0, vecs[i].exp});
        end

        // Asynchronous reset mid-run, away from any clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc_src_q", {30'd0, pc_src_q}, 32'd0);
        check("async_rst_br_count", br_count, 32'd0);
        check("async_rst_taken_count", taken_count, 32'd0);
        check("async_rst_comb_unaffected", {30'd0, pc_src}, 32'd1);

        // Release, then three BEQ-taken edges
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_pc_src_q", {30'd0, pc_src_q}, 32'd1);
`ifdef BRANCH_STATS_EN
        check("post_rst_br_count", br_count, 32'd3);
        check("post_rst_taken_count", taken_count, 32'd3);

        // Untaken branch counts as executed, not as a redirect
        @(negedge clk);
        drive(6'd5, 5'd0, 6'd0, 32'd7, 32'd7);
        @(posedge clk);
        #1;
        check("untaken_br_count", br_count, 32'd4);
        check("untaken_taken_count", taken_count, 32'd3);

        // Non-branch leaves both counters alone
        @(negedge clk);
        drive(6'd0, 5'd0, 6'b100000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check("nonbr_br_count", br_count, 32'd4);
        check("nonbr_taken_count", taken_count, 32'd3);

        // Preload near all-ones and wrap on the next taken branch
        @(negedge clk);
        drive(6'd2, 5'd0, 6'd0, 32'd0, 32'd0);
        force dut.br_count_q    = 32'hFFFF_FFFF;
        force dut.taken_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_q;
        release dut.taken_count_q;
        @(posedge clk);
        #1;
        check("wrap_br_count", br_count, 32'd0);
        check("wrap_taken_count", taken_count, 32'd0);
`else
        check("nostats_br_count", br_count, 32'd0);
        check("nostats_taken_count", taken_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_branch

`default_nettype wire
